// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default bus width and
// index-width helpers used by stream plumbing blocks.
package cpu_pkg;

    localparam int BUS_W = 32;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotates requests so ptr lands at bit 0,
// picks the lowest set bit, then rotates the grant back.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt
);

    localparam logic [NUM_IN-1:0] ONE =
        {{(NUM_IN-1){1'b0}}, 1'b1};

    logic [2*NUM_IN-1:0] dbl_req;
    logic [2*NUM_IN-1:0] rot_full;
    logic [2*NUM_IN-1:0] dbl_gnt;
    logic [2*NUM_IN-1:0] unrot_full;
    logic [NUM_IN-1:0]   rot_req;
    logic [NUM_IN-1:0]   rot_gnt;
    logic                unused_bits;

    always_comb begin
        dbl_req    = {req, req};
        rot_full   = dbl_req >> ptr;
        rot_req    = rot_full[NUM_IN-1:0];
        // Isolate the lowest set bit: first requester at/after ptr.
        rot_gnt    = rot_req & (~rot_req + ONE);
        dbl_gnt    = {rot_gnt, rot_gnt};
        unrot_full = dbl_gnt << ptr;
        gnt        = unrot_full[2*NUM_IN-1:NUM_IN];
    end

    assign unused_bits = ^{rot_full[2*NUM_IN-1:NUM_IN],
                           unrot_full[NUM_IN-1:0]};

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with a one-entry output register;
// source picked by round-robin or by an external select.
module stream_mux_rr
    import cpu_pkg::*;
#(
    parameter int WIDTH   = BUS_W,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = clog2_min1(NUM_IN),
    parameter int RR_MODE = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_next;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  gidx;
    logic [WIDTH-1:0]  gdata;
    logic              load_en;
    logic              take;

    assign load_en = !out_valid || out_ready;

    generate
        if (RR_MODE != 0) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            rr_arbiter #(
                .NUM_IN (NUM_IN),
                .PTR_W  (SEL_W)
            ) u_arb (
                .req (in_valid),
                .ptr (ptr),
                .gnt (grant)
            );
        end else begin : g_ext
            logic unused_ptr;
            assign unused_ptr = ^ptr;

            // Out-of-range sel matches no channel, so nothing is granted.
            for (genvar i = 0; i < NUM_IN; i++) begin : g_sel
                assign grant[i] = in_valid[i] && (sel == SEL_W'(i));
            end
        end
    endgenerate

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                gidx  = SEL_W'(i);
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (resetn && load_en) ? grant : '0;
    assign take     = |in_ready;

    // Explicit wrap keeps non-power-of-two channel counts in range.
    assign ptr_next = (gidx == SEL_W'(NUM_IN - 1)) ? '0
                                                   : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_src   <= gidx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: round-robin instance against a
// behavioural model, plus two external-select instances.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Round-robin instance, 4 channels
    logic [3:0]   rv;
    logic [127:0] rd;
    logic [3:0]   rrdy;
    logic [1:0]   rsel;
    logic         rov;
    logic [31:0]  rod;
    logic [1:0]   ros;
    logic         ror;

    stream_mux_rr #(.WIDTH(32), .NUM_IN(4), .RR_MODE(1)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(rv), .in_data(rd), .in_ready(rrdy),
        .sel(rsel),
        .out_valid(rov), .out_data(rod), .out_src(ros),
        .out_ready(ror)
    );

    // External select, 4 channels
    logic [3:0]   ev;
    logic [127:0] ed;
    logic [3:0]   erdy;
    logic [1:0]   esel;
    logic         eov;
    logic [31:0]  eod;
    logic [1:0]   eos;
    logic         eor;

    stream_mux_rr #(.WIDTH(32), .NUM_IN(4), .RR_MODE(0)) dut_ext (
        .clk(clk), .resetn(resetn),
        .in_valid(ev), .in_data(ed), .in_ready(erdy),
        .sel(esel),
        .out_valid(eov), .out_data(eod), .out_src(eos),
        .out_ready(eor)
    );

    // External select, 3 channels
    logic [2:0]  tv;
    logic [95:0] td;
    logic [2:0]  trdy;
    logic [1:0]  tsel;
    logic        tov;
    logic [31:0] tod;
    logic [1:0]  tos;
    logic        tor;

    stream_mux_rr #(.WIDTH(32), .NUM_IN(3), .RR_MODE(0)) dut_ext3 (
        .clk(clk), .resetn(resetn),
        .in_valid(tv), .in_data(td), .in_ready(trdy),
        .sel(tsel),
        .out_valid(tov), .out_data(tod), .out_src(tos),
        .out_ready(tor)
    );

    // Reference model state for the round-robin instance
    logic        m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;

    function automatic int rr_pick(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock of the RR instance, checked against the model.
    task automatic rr_cycle();
        int         g;
        logic [3:0] exp_rdy;
        logic       le;
        #1;
        le      = !m_valid || ror;
        g       = rr_pick(rv, m_ptr);
        exp_rdy = 4'b0;
        if (resetn && le && g >= 0) exp_rdy[g] = 1'b1;
        n_checks++;
        if (rrdy !== exp_rdy) begin
            n_fail++;
            $display("FAIL rr_in_ready: got %b want %b t=%0t",
                     rrdy, exp_rdy, $time);
        end
        @(posedge clk);
        if (!resetn) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
        end else if (exp_rdy != 4'b0) begin
            m_valid = 1'b1;
            m_data  = rd[g*32 +: 32];
            m_src   = g;
            m_ptr   = (g + 1) % 4;
        end else if (ror) begin
            m_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (rov !== m_valid || rod !== m_data ||
            ros !== 2'(m_src) || dut.ptr !== 2'(m_ptr)) begin
            n_fail++;
            $display("FAIL rr_out: got v=%b d=%h s=%0d p=%0d want v=%b d=%h s=%0d p=%0d",
                     rov, rod, ros, dut.ptr,
                     m_valid, m_data, m_src, m_ptr);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rv = 4'hF; ror = 1'b1;
        for (int i = 0; i < 4; i++) rd[i*32 +: 32] = 32'h10 + i;
        repeat (3) begin
            rr_cycle();
            n_checks++;
            if (rov !== 1'b0 || rod !== 32'h0 ||
                ros !== 2'd0 || rrdy !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_state: v=%b d=%h s=%0d rdy=%b",
                         rov, rod, ros, rrdy);
            end
        end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (rrdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_ready: got %b want 0001", rrdy);
        end
        rr_cycle();
        n_checks++;
        if (rov !== 1'b1 || ros !== 2'd0 || rod !== 32'h10) begin
            n_fail++;
            $display("FAIL reset_first_out: v=%b s=%0d d=%h want 1 0 10",
                     rov, ros, rod);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_d [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        resetn = 1'b0;
        rr_cycle();
        resetn = 1'b1;
        rv = 4'hF; ror = 1'b1;
        for (int i = 0; i < 4; i++) rd[i*32 +: 32] = 32'hA0 + i;
        for (int k = 0; k < 5; k++) begin
            rr_cycle();
            n_checks++;
            if (rod !== exp_d[k] || ros !== 2'(k % 4) || rov !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: d=%h s=%0d want d=%h s=%0d",
                         k, rod, ros, exp_d[k], k % 4);
            end
        end
    endtask

    task automatic test_skipping();
        rv = 4'b0010;
        rr_cycle();
        n_checks++;
        if (dut.ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL skip_setup_ptr: got %0d want 2", dut.ptr);
        end
        rv = 4'b1010;
        rr_cycle();
        n_checks++;
        if (ros !== 2'd3 || dut.ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL skip_ch3: src=%0d ptr=%0d want 3 0", ros, dut.ptr);
        end
        rr_cycle();
        n_checks++;
        if (ros !== 2'd1 || dut.ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL skip_ch1: src=%0d ptr=%0d want 1 2", ros, dut.ptr);
        end
        rr_cycle();
        n_checks++;
        if (ros !== 2'd3) begin
            n_fail++;
            $display("FAIL skip_ch3b: src=%0d want 3", ros);
        end
    endtask

    task automatic test_backpressure();
        rv = 4'b0001; ror = 1'b1;
        rd[31:0]  = 32'hDEADBEEF;
        rd[63:32] = 32'h12345678;
        rr_cycle();
        ror = 1'b0;
        rv  = 4'b0010;
        repeat (4) begin
            rr_cycle();
            n_checks++;
            if (rod !== 32'hDEADBEEF || rov !== 1'b1 || rrdy !== 4'h0) begin
                n_fail++;
                $display("FAIL backpressure_hold: d=%h v=%b rdy=%b",
                         rod, rov, rrdy);
            end
        end
        ror = 1'b1;
        rr_cycle();
        n_checks++;
        if (rov !== 1'b1 || rod !== 32'h12345678 || ros !== 2'd1) begin
            n_fail++;
            $display("FAIL backpressure_release: v=%b d=%h s=%0d want 1 12345678 1",
                     rov, rod, ros);
        end
    endtask

    task automatic test_reset_mid();
        rv = 4'b0100; ror = 1'b0;
        rd[95:64] = 32'hCAFE0002;
        rr_cycle();
        rv = 4'b0;
        rr_cycle();
        resetn = 1'b0;
        rr_cycle();
        n_checks++;
        if (rov !== 1'b0 || dut.ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b ptr=%0d want 0 0", rov, dut.ptr);
        end
        resetn = 1'b1; ror = 1'b1;
        rr_cycle();
        n_checks++;
        if (rov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_lost: v=%b want 0", rov);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            resetn = ($urandom_range(0, 59) != 0);
            rv     = 4'($urandom);
            rd     = {$urandom, $urandom, $urandom, $urandom};
            ror    = ($urandom_range(0, 3) != 0);
            rr_cycle();
        end
        resetn = 1'b1;
    endtask

    task automatic test_external();
        logic [1:0] s;
        eor = 1'b1;
        ev  = 4'hF;
        for (int k = 0; k < 6; k++) begin
            s    = (k == 0) ? 2'd2 : 2'($urandom);
            esel = s;
            ed   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_checks++;
            if (erdy !== (4'b0001 << s)) begin
                n_fail++;
                $display("FAIL ext_ready sel=%0d: got %b", s, erdy);
            end
            @(posedge clk); #1;
            n_checks++;
            if (eov !== 1'b1 || eos !== s || eod !== ed[s*32 +: 32]) begin
                n_fail++;
                $display("FAIL ext_out sel=%0d: v=%b s=%0d d=%h",
                         s, eov, eos, eod);
            end
        end
        // 3-channel instance: load one word, then select out of range
        tor = 1'b1; tv = 3'b111;
        td  = {32'hC2, 32'hC1, 32'hC0};
        tsel = 2'd1;
        @(posedge clk); #1;
        n_checks++;
        if (tov !== 1'b1 || tos !== 2'd1 || tod !== 32'hC1) begin
            n_fail++;
            $display("FAIL ext3_load: v=%b s=%0d d=%h", tov, tos, tod);
        end
        tsel = 2'd3;
        #1;
        n_checks++;
        if (trdy !== 3'b000) begin
            n_fail++;
            $display("FAIL ext3_no_grant: rdy=%b want 000", trdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (tov !== 1'b0) begin
            n_fail++;
            $display("FAIL ext3_drain: v=%b want 0", tov);
        end
    endtask

    initial begin
        resetn = 1'b0;
        rv = '0; rd = '0; rsel = '0; ror = 1'b1;
        ev = '0; ed = '0; esel = '0; eor = 1'b1;
        tv = '0; td = '0; tsel = '0; tor = 1'b1;
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
        test_reset();
        test_round_robin();
        test_skipping();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_external();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
N-input, width-parametrised stream multiplexer with valid/ready handshakes and a one-entry registered output stage. It generalises the 2:1 combinational data mux in two ways: an arbitrary channel count, and a selectable mode (externally steered select, or round-robin arbitration). It sits between multiple producers in the multi-cycle CPU datapath (e.g. fetch/LSU requests) and a single shared consumer such as the memory port.

Parameters:
WIDTH, 32, data width per channel
NUM_IN, 4, number of input channels (2..16)
SEL_W, $clog2(NUM_IN), select/source index width (derived; do not override)
RR_MODE, 1, 1 = round-robin arbitration; 0 = external select via sel

Ports:
clk  input  1  rising-edge clock
resetn  input  1  synchronous active-low reset
in_valid  input  NUM_IN  per-channel valid
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  NUM_IN  per-channel ready (combinational)
sel  input  SEL_W  channel select, used only when RR_MODE=0
out_valid  output  1  registered output valid
out_data  output  WIDTH  registered output data
out_src  output  SEL_W  index of the channel that supplied out_data
out_ready  input  1  consumer ready

Behaviour:
- One clock (clk). Reset is synchronous and active-low (resetn sampled on the rising edge of clk).
- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. in_ready is all-zero while resetn=0.
- Reset mid-operation: a buffered word is dropped and is not delivered.
- load_en = !out_valid || out_ready. The output register accepts a word when it is empty, or when it is being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - RR_MODE=1: grant the first channel with in_valid=1, searching ptr, ptr+1, … NUM_IN-1, 0, … ptr-1.
  - RR_MODE=0: grant channel sel if in_valid[sel]=1. If sel >= NUM_IN, grant nothing.
- in_ready[i] = grant[i] && load_en && resetn. At most one in_ready bit is high per cycle. in_ready may depend on in_valid (arbitration). Producers must not make in_valid depend on in_ready.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge: out_data <= in_data[i], out_src <= i, out_valid <= 1.
- If load_en=1 and no channel is granted: out_valid <= 0 when out_ready=1; otherwise out_valid holds.
- Latency: one cycle from input accept to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_data and out_src hold stable and all in_ready are 0.
- Pointer: after a transfer from channel i, ptr <= (i+1) mod NUM_IN. The wrap from NUM_IN-1 goes to 0, including non-power-of-two NUM_IN. ptr is unchanged on cycles with no transfer. ptr is ignored when RR_MODE=0.
- Simultaneous drain and load in one cycle: the new word replaces the old one with no bubble.
- Fairness: any continuously valid channel is granted within NUM_IN transfers.

Decomposition:
- Shared package cpu_pkg: a constant for the default bus width (32), and a function clog2_min1 returning max(1, $clog2(n)) so SEL_W is never 0.
- One natural sub-module, rr_arbiter. Parameter NUM_IN; inputs req, ptr; output one-hot gnt.
  - Implement with the double-width rotate-and-priority-encode method.
  - stream_mux_rr bypasses it when RR_MODE=0.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with all in_valid=1. Expect out_valid=0, out_data=0, out_src=0, in_ready=0. Release reset: first accept is from ch0, and out_valid=1 one cycle later.
- Round-robin: NUM_IN=4, all channels valid, ch i data = 0xA0+i, out_ready=1. Expect out_data sequence A0,A1,A2,A3,A0 on consecutive cycles and out_src 0,1,2,3,0.
- Skipping: only ch1 and ch3 valid, ptr=2. Expect ch3 then ch1 then ch3. ptr reads 0 after the ch3 grant and 2 after the ch1 grant.
- Backpressure: out_ready=0 for 4 cycles after a load of 0xDEADBEEF. Expect out_data stable, in_ready=0. Release: the next word loads in the same cycle as the drain, with no bubble.
- External mode: RR_MODE=0, sel=2, ch0..3 all valid. Expect only in_ready[2] high and out_src=2. With NUM_IN=3 and sel=3: no grant, and out_valid drops after the drain.
- Reset mid-stream: assert resetn=0 while out_valid=1 and out_ready=0. Expect the word to be lost, out_valid=0 next edge, and ptr=0.
